// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte to a PS/2 device over the open-collector clock/data pair.
// The lines are only ever pulled low through the *_oe outputs.
// Optional macro PS2_TX_RETRY_EN: a failed attempt (bad ACK or device clock
// stall) restarts from the inhibit phase with the latched byte, up to two
// retries, before the error is reported.
//
// Ports:
//   clk, clr            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw PS/2 pad inputs (synchronised here)
//   tx_data, tx_valid   command byte and send request
//   tx_ready            high in IDLE only; accept = tx_valid & tx_ready
//   ps2_clk_oe          1 = pull ps2_clk low
//   ps2_data_oe         1 = pull ps2_data low
//   busy                high in every state except IDLE
//   done                one-cycle pulse: byte sent, ACK seen, lines idle
//   ack_err             one-cycle pulse: ACK bit sampled high
//   timeout             one-cycle pulse: device clock stalled

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  // One counter serves the inhibit, request-to-send and stall phases.
  localparam int CW = $clog2(INHIBIT_CYCLES + RTS_CYCLES + TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic [CW-1:0] cnt;
  logic [7:0]    tx_byte;
  logic [7:0]    shreg;
  logic          parity;
  logic [3:0]    bitcnt;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  logic fe;
  logic in_wait;
  logic fail_ack;
  logic fail_to;

  assign fe       = clk_prev & ~clk_s2;
  assign in_wait  = (state == S_SEND) || (state == S_WAIT_ACK) || (state == S_WAIT_IDLE);
  assign fail_ack = (state == S_WAIT_ACK) && fe && data_s2;
  // A falling edge in the same cycle restarts the stall window instead.
  assign fail_to  = in_wait && !fe && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_prev    <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      cnt         <= '0;
      tx_byte     <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      bitcnt      <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;

      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;

      if (fail_ack || fail_to) begin
`ifdef PS2_TX_RETRY_EN
        if (retry_cnt != 2'd2) begin
          // Restart the whole handshake with the byte latched at accept.
          retry_cnt   <= retry_cnt + 2'd1;
          state       <= S_INHIBIT;
          cnt         <= '0;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
        end else begin
          state       <= S_IDLE;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          ack_err     <= fail_ack;
          timeout     <= fail_to;
        end
`else
        state       <= S_IDLE;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        ack_err     <= fail_ack;
        timeout     <= fail_to;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (tx_valid) begin
              tx_byte    <= tx_data;
              parity     <= ~^tx_data;
              cnt        <= '0;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_cnt  <= '0;
`endif
            end
          end

          S_INHIBIT: begin
            if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;  // start bit
              state       <= S_RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_RTS: begin
            if (cnt == CW'(RTS_CYCLES - 1)) begin
              cnt        <= '0;
              bitcnt     <= '0;
              shreg      <= tx_byte;
              ps2_clk_oe <= 1'b0;   // hand the clock to the device
              state      <= S_SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_SEND: begin
            if (fe) begin
              cnt    <= '0;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt < 4'd8) begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[7:1]};
              end else if (bitcnt == 4'd8) begin
                ps2_data_oe <= ~parity;
              end else begin
                ps2_data_oe <= 1'b0;  // stop bit: release data
                state       <= S_WAIT_ACK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_WAIT_ACK: begin
            // A high ACK was handled above as fail_ack.
            if (fe) begin
              cnt   <= '0;
              state <= S_WAIT_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_WAIT_IDLE: begin
            if (clk_s2 && data_s2) begin
              done     <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (fe) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 4;
  localparam int TMO = 200;
  localparam int H   = 20;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_w, ps2_data_w;

  // Open-collector bus: low if either side pulls it low.
  assign ps2_clk_w  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_w = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk_w),
    .ps2_data   (ps2_data_w),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0, ackerr_cnt = 0, to_cnt = 0, to_cyc = 0, accept_cnt = 0;
  int last_fe = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!clr && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
  end

  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (ack_err) ackerr_cnt = ackerr_cnt + 1;
    if (timeout) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte, then measure the inhibit and request-to-send phases.
  task automatic host_start(input logic [7:0] b, input logic hold, input string nm);
    int n1, n2;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    chk({nm, "_latency"}, {31'd0, ps2_clk_oe}, 32'd1);
    n1 = 0;
    while (ps2_clk_oe && !ps2_data_oe && n1 < 100) begin
      n1++;
      @(negedge clk);
      if (hold) tx_data = tx_data + 8'h37;
    end
    n2 = 0;
    while (ps2_clk_oe && ps2_data_oe && n2 < 100) begin
      n2++;
      @(negedge clk);
      if (hold) tx_data = tx_data + 8'h37;
    end
    chk({nm, "_inhibit_len"}, n1, INH);
    chk({nm, "_rts_len"}, n2, RTS);
  endtask

  // Device side: clock out nclk bit slots (up to 10), then an ACK slot if nclk > 10.
  task automatic dev_xfer(input int nclk, input logic ack_val, output logic [9:0] bits);
    bits = '1;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nclk && i < 10; i++) begin
      dev_clk = 1'b0;
      last_fe = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
      bits[i] = ps2_data_w;
      repeat (H / 2) @(negedge clk);
    end
    if (nclk > 10) begin
      dev_data = ack_val;
      repeat (H / 2) @(negedge clk);
      dev_clk = 1'b0;
      last_fe = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_idle_bound"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic xfer_ok(input logic [7:0] b, input logic exp_par, input string nm);
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = ackerr_cnt;
    host_start(b, 1'b0, nm);
    dev_xfer(11, 1'b0, bits);
    wait_idle(nm);
    @(negedge clk);
    chk({nm, "_byte"}, {24'd0, bits[7:0]}, {24'd0, b});
    chk({nm, "_parity"}, {31'd0, bits[8]}, {31'd0, exp_par});
    chk({nm, "_stop"}, {31'd0, bits[9]}, 32'd1);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_ack_err"}, ackerr_cnt - e0, 0);
    chk({nm, "_ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, t0, a0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("rst_pulses", {29'd0, done, ack_err, timeout}, 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Hand-computed odd parity: ED has six ones, 01 one, FF eight, 00 none.
    xfer_ok(8'hED, 1'b1, "ed");
    xfer_ok(8'h01, 1'b0, "x01");
    xfer_ok(8'hFF, 1'b1, "ff");
    xfer_ok(8'h00, 1'b1, "x00");

    // Device leaves data high in the ACK slot.
    d0 = done_cnt;
    e0 = ackerr_cnt;
    host_start(8'hF3, 1'b0, "nak");
    dev_xfer(11, 1'b1, bits);
    wait_idle("nak");
    @(negedge clk);
    chk("nak_ack_err", ackerr_cnt - e0, 1);
    chk("nak_done", done_cnt - d0, 0);
    chk("nak_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // Device stops clocking after bit 3: fe is seen 3 clk after the pin
    // falls, then the pulse lands TMO cycles later.
    t0 = to_cnt;
    host_start(8'hAA, 1'b0, "stall");
    dev_xfer(3, 1'b0, bits);
    wait_idle("stall");
    @(negedge clk);
    chk("stall_timeout", to_cnt - t0, 1);
    chk("stall_delay", to_cyc - last_fe, TMO + 3);
    chk("stall_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("stall_ready", {31'd0, tx_ready}, 32'd1);

    // Reset during bit 5 releases everything on the next edge.
    host_start(8'h96, 1'b0, "clr");
    dev_xfer(5, 1'b0, bits);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_ready", {31'd0, tx_ready}, 32'd1);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    xfer_ok(8'hF4, 1'b0, "f4");

    // tx_valid held with changing tx_data: only the accepted byte goes out.
    a0 = accept_cnt;
    d0 = done_cnt;
    host_start(8'h5A, 1'b1, "hold");
    fork
      dev_xfer(11, 1'b0, bits);
      begin
        repeat (200) begin
          @(negedge clk);
          tx_data = tx_data ^ 8'hC3;
        end
        tx_valid = 1'b0;
      end
    join
    wait_idle("hold");
    @(negedge clk);
    chk("hold_byte", {24'd0, bits[7:0]}, 32'h5A);
    chk("hold_parity", {31'd0, bits[8]}, 32'd1);
    chk("hold_accepts", accept_cnt - a0, 1);
    chk("hold_done", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
